// File: rtl/mem_io_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_io_responder_if
// Description : Bus bundle between a memory/IO initiator and mem_io_responder.
//               Carries the byte-wide load/store port, the TX FIFO sink side
//               and the RX byte source side.
//   master modport : initiator/environment side (drives requests, sinks TX,
//                    sources RX)
//   slave  modport : mem_io_responder side
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_io_responder_if;
    logic        rw_select;       // 0 read, 1 write
    logic [17:0] addr_in;         // byte address
    logic [7:0]  ram_store_data;  // write byte
    logic [7:0]  ram_load_data;   // registered read byte
    logic        io_buffer_full;  // TX FIFO near-full back-pressure
    logic [7:0]  uart_tx_data;    // TX FIFO head byte
    logic        uart_tx_valid;   // TX FIFO non-empty
    logic        uart_tx_ready;   // sink accepts head byte
    logic [7:0]  uart_rx_data;    // incoming byte
    logic        uart_rx_valid;   // incoming byte present
    logic        uart_rx_pop;     // consumes uart_rx_data
    logic        program_finish;  // sticky halt flag

    modport master (
        output rw_select, addr_in, ram_store_data,
        output uart_tx_ready, uart_rx_data, uart_rx_valid,
        input  ram_load_data, io_buffer_full, uart_tx_data, uart_tx_valid,
        input  uart_rx_pop, program_finish
    );

    modport slave (
        input  rw_select, addr_in, ram_store_data,
        input  uart_tx_ready, uart_rx_data, uart_rx_valid,
        output ram_load_data, io_buffer_full, uart_tx_data, uart_tx_valid,
        output uart_rx_pop, program_finish
    );
endinterface
`default_nettype wire

// File: rtl/mem_io_responder.sv
`default_nettype none
// ============================================================================
// Module      : mem_io_responder
// Description : Byte-wide RAM plus memory-mapped IO responder.
//               addr_in[17:16]==2'b11 selects IO space, anything else hits
//               RAM at addr_in[ADDR_WIDTH-1:0].
//                 IO write 0x30000 : push byte into TX FIFO (dropped if full)
//                 IO write 0x30004 : set sticky program_finish
//                 IO read  0x30000 : RX byte (+ uart_rx_pop) if valid, else 0
//                 IO read  0x30004 : {7'b0, uart_rx_valid}
//               Every cycle with rdy_in=1 is an access; rdy_in=0 freezes all
//               state.
//   Ports     : clk_in    - system clock, all state on posedge
//               rst_n_in  - asynchronous active-low reset
//               rdy_in    - high = operate, low = freeze
//               bus       - mem_io_responder_if.slave (load/store, TX, RX)
//   Parameters: ADDR_WIDTH - RAM byte-address width (default 17)
//               FIFO_AW    - log2 of TX FIFO depth (default 3)
//   Macro     : MEM_IO_RX_EN - when defined, the RX read path is active;
//               otherwise RX reads return 0 and uart_rx_pop stays low.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_io_responder #(
    parameter int ADDR_WIDTH = 17,
    parameter int FIFO_AW    = 3
) (
    input  wire logic          clk_in,
    input  wire logic          rst_n_in,
    input  wire logic          rdy_in,
    mem_io_responder_if.slave  bus
);

    localparam int               c_DEPTH      = 1 << FIFO_AW;
    localparam int               c_RAM_BYTES  = 1 << ADDR_WIDTH;
    localparam logic [17:0]      c_IO_TX_ADDR = 18'h30000;
    localparam logic [17:0]      c_IO_CTL_ADDR = 18'h30004;
    localparam logic [FIFO_AW:0] c_FULL_CNT   = (FIFO_AW+1)'(c_DEPTH);
    // Two entries of headroom: a store already in flight when the initiator
    // sees back-pressure still has a slot to land in.
    localparam logic [FIFO_AW:0] c_NEAR_FULL  = (FIFO_AW+1)'(c_DEPTH - 2);

    // Storage (never reset)
    logic [7:0]           r_ram  [c_RAM_BYTES];
    logic [7:0]           r_fifo [c_DEPTH];

    // Control state
    logic [FIFO_AW-1:0]   r_wr_ptr;
    logic [FIFO_AW-1:0]   r_rd_ptr;
    logic [FIFO_AW:0]     r_count;
    logic [7:0]           r_load_data;
    logic                 r_full;
    logic                 r_rx_pop;
    logic                 r_finish;

    // Decode
    logic                  w_is_io;
    logic [ADDR_WIDTH-1:0] w_ram_addr;
    logic                  w_ram_wr;
    logic                  w_push;
    logic                  w_drain;
    logic                  w_finish_set;
    logic [FIFO_AW:0]      w_count_next;
    logic [7:0]            w_io_rdata;
    logic                  w_rx_pop_next;

    assign w_is_io      = (bus.addr_in[17:16] == 2'b11);
    assign w_ram_addr   = bus.addr_in[ADDR_WIDTH-1:0];
    assign w_ram_wr     = rdy_in && bus.rw_select && !w_is_io;
    // A push into a completely full FIFO is silently dropped.
    assign w_push       = rdy_in && bus.rw_select && (bus.addr_in == c_IO_TX_ADDR)
                          && (r_count != c_FULL_CNT);
    assign w_drain      = rdy_in && (r_count != '0) && bus.uart_tx_ready;
    assign w_finish_set = rdy_in && bus.rw_select && (bus.addr_in == c_IO_CTL_ADDR);

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_drain})
            2'b10:   w_count_next = r_count + 1'b1;
            2'b01:   w_count_next = r_count - 1'b1;
            default: w_count_next = r_count;
        endcase
    end

    // IO read mux
`ifdef MEM_IO_RX_EN
    always_comb begin
        w_io_rdata    = 8'h00;
        w_rx_pop_next = 1'b0;
        if (bus.addr_in == c_IO_TX_ADDR) begin
            if (bus.uart_rx_valid) begin
                w_io_rdata    = bus.uart_rx_data;
                w_rx_pop_next = 1'b1;
            end
        end else if (bus.addr_in == c_IO_CTL_ADDR) begin
            w_io_rdata = {7'b0, bus.uart_rx_valid};
        end
    end
`else
    logic w_unused_rx;
    assign w_unused_rx   = ^{bus.uart_rx_data, bus.uart_rx_valid};
    assign w_io_rdata    = 8'h00;
    assign w_rx_pop_next = 1'b0;
`endif

    // RAM and FIFO storage writes
    always_ff @(posedge clk_in) begin
        if (w_ram_wr) begin
            r_ram[w_ram_addr] <= bus.ram_store_data;
        end
        if (w_push) begin
            r_fifo[r_wr_ptr] <= bus.ram_store_data;
        end
    end

    // Control registers
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_load_data <= 8'h00;
            r_full      <= 1'b0;
            r_rx_pop    <= 1'b0;
            r_finish    <= 1'b0;
        end else if (rdy_in) begin
            r_rx_pop <= 1'b0;
            // Writes leave the load register untouched.
            if (!bus.rw_select) begin
                if (w_is_io) begin
                    r_load_data <= w_io_rdata;
                    r_rx_pop    <= w_rx_pop_next;
                end else begin
                    r_load_data <= r_ram[w_ram_addr];
                end
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_drain) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= w_count_next;
            r_full  <= (w_count_next >= c_NEAR_FULL);
            if (w_finish_set) begin
                r_finish <= 1'b1;
            end
        end else begin
            // Frozen: everything holds, but the pop pulse must not repeat.
            r_rx_pop <= 1'b0;
        end
    end

    assign bus.ram_load_data  = r_load_data;
    assign bus.io_buffer_full = r_full;
    assign bus.uart_tx_data   = r_fifo[r_rd_ptr];
    assign bus.uart_tx_valid  = (r_count != '0);
    assign bus.uart_rx_pop    = r_rx_pop;
    assign bus.program_finish = r_finish;

endmodule
`default_nettype wire

// File: tb/tb_mem_io_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_io_responder
// Description : Directed self-checking bench for mem_io_responder covering
//               reset, RAM load/store, TX FIFO fill/drain/wrap, RX reads,
//               rdy_in freeze and the sticky finish flag. Expected RX results
//               follow MEM_IO_RX_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_io_responder;

    logic clk_in   = 1'b0;
    logic rst_n_in = 1'b0;
    logic rdy_in   = 1'b1;

    int n_pass  = 0;
    int n_total = 0;

    logic [7:0] exp_q[$];

    mem_io_responder_if u_bus ();

    mem_io_responder #(
        .ADDR_WIDTH (17),
        .FIFO_AW    (3)
    ) u_dut (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .rdy_in   (rdy_in),
        .bus      (u_bus.slave)
    );

    always #5 clk_in = ~clk_in;

    task automatic check_value(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic drive(input logic rw, input logic [17:0] a, input logic [7:0] d);
        u_bus.rw_select      = rw;
        u_bus.addr_in        = a;
        u_bus.ram_store_data = d;
    endtask

    initial begin
        logic [7:0] rx_exp;
        logic       pop_exp;

        drive(1'b0, 18'h00010, 8'h00);
        u_bus.uart_tx_ready = 1'b0;
        u_bus.uart_rx_data  = 8'h00;
        u_bus.uart_rx_valid = 1'b0;

        // Reset state
        tick();
        tick();
        check_value("rst_load",   u_bus.ram_load_data,  8'h00);
        check_value("rst_full",   u_bus.io_buffer_full, 1'b0);
        check_value("rst_valid",  u_bus.uart_tx_valid,  1'b0);
        check_value("rst_pop",    u_bus.uart_rx_pop,    1'b0);
        check_value("rst_finish", u_bus.program_finish, 1'b0);

        // RAM store / load
        rst_n_in = 1'b1;
        drive(1'b1, 18'h00010, 8'hA5);
        tick();
        check_value("wr_holds_load", u_bus.ram_load_data, 8'h00);
        drive(1'b0, 18'h00010, 8'h00);
        tick();
        check_value("rd_10", u_bus.ram_load_data, 8'hA5);
        drive(1'b1, 18'h1FFFF, 8'h3C);
        tick();
        check_value("wr_top_holds", u_bus.ram_load_data, 8'hA5);
        drive(1'b0, 18'h1FFFF, 8'h00);
        tick();
        check_value("rd_top", u_bus.ram_load_data, 8'h3C);

        // Unmapped IO: write ignored, read returns zero
        drive(1'b1, 18'h30008, 8'h77);
        tick();
        check_value("io_unmapped_nopush", u_bus.uart_tx_valid, 1'b0);
        drive(1'b0, 18'h30008, 8'h00);
        tick();
        check_value("io_unmapped_rd", u_bus.ram_load_data, 8'h00);

        // TX FIFO fill with sink stalled; ninth byte is dropped
        for (int i = 1; i <= 9; i++) begin
            drive(1'b1, 18'h30000, 8'(i));
            tick();
            check_value($sformatf("fill_valid_%0d", i), u_bus.uart_tx_valid, 1'b1);
            check_value($sformatf("fill_full_%0d", i), u_bus.io_buffer_full,
                        (i >= 6) ? 32'd1 : 32'd0);
        end
        check_value("fill_head", u_bus.uart_tx_data, 8'h01);

        // Drain in order
        drive(1'b0, 18'h00010, 8'h00);
        u_bus.uart_tx_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            check_value($sformatf("drain_%0d", i), u_bus.uart_tx_data, 8'(i));
            tick();
        end
        check_value("drain_empty", u_bus.uart_tx_valid,  1'b0);
        check_value("drain_full0", u_bus.io_buffer_full, 1'b0);

        // Simultaneous push/drain across pointer wrap
        u_bus.uart_tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 18'h30000, 8'hA0 + 8'(i));
            exp_q.push_back(8'hA0 + 8'(i));
            tick();
        end
        u_bus.uart_tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check_value($sformatf("wrap_head_%0d", i), u_bus.uart_tx_data, exp_q[0]);
            drive(1'b1, 18'h30000, 8'hB0 + 8'(i));
            exp_q.push_back(8'hB0 + 8'(i));
            void'(exp_q.pop_front());
            tick();
            check_value($sformatf("wrap_valid_%0d", i), u_bus.uart_tx_valid, 1'b1);
        end
        drive(1'b0, 18'h00010, 8'h00);
        while (exp_q.size() > 0) begin
            check_value("wrap_tail", u_bus.uart_tx_data, exp_q[0]);
            void'(exp_q.pop_front());
            tick();
        end
        check_value("wrap_empty", u_bus.uart_tx_valid, 1'b0);

        // RX reads
`ifdef MEM_IO_RX_EN
        rx_exp  = 8'h5A;
        pop_exp = 1'b1;
`else
        rx_exp  = 8'h00;
        pop_exp = 1'b0;
`endif
        u_bus.uart_rx_valid = 1'b1;
        u_bus.uart_rx_data  = 8'h5A;
        drive(1'b0, 18'h30000, 8'h00);
        tick();
        check_value("rx_data", u_bus.ram_load_data, rx_exp);
        check_value("rx_pop",  u_bus.uart_rx_pop,   pop_exp);
        drive(1'b0, 18'h30004, 8'h00);
        tick();
        check_value("rx_stat_1",   u_bus.ram_load_data, {7'b0, pop_exp});
        check_value("rx_pop_once", u_bus.uart_rx_pop,   1'b0);
        u_bus.uart_rx_valid = 1'b0;
        tick();
        check_value("rx_stat_0", u_bus.ram_load_data, 8'h00);
        drive(1'b0, 18'h00010, 8'h00);
        tick();
        drive(1'b0, 18'h30000, 8'h00);
        tick();
        check_value("rx_empty_data", u_bus.ram_load_data, 8'h00);
        check_value("rx_empty_pop",  u_bus.uart_rx_pop,   1'b0);

        // rdy_in freeze
        u_bus.uart_tx_ready = 1'b0;
        drive(1'b1, 18'h30000, 8'hC0);
        tick();
        drive(1'b1, 18'h30000, 8'hC1);
        tick();
        drive(1'b0, 18'h00010, 8'h00);
        tick();
        check_value("pre_freeze_load", u_bus.ram_load_data, 8'hA5);
        rdy_in = 1'b0;
        u_bus.uart_tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            case (i)
                0:       drive(1'b0, 18'h1FFFF, 8'h00);
                1:       drive(1'b1, 18'h00010, 8'hEE);
                2:       drive(1'b1, 18'h30000, 8'hD0);
                default: drive(1'b1, 18'h30004, 8'h00);
            endcase
            tick();
            check_value($sformatf("frz_load_%0d", i), u_bus.ram_load_data, 8'hA5);
            check_value($sformatf("frz_head_%0d", i), u_bus.uart_tx_data,  8'hC0);
        end
        check_value("frz_finish", u_bus.program_finish, 1'b0);
        rdy_in = 1'b1;
        u_bus.uart_tx_ready = 1'b0;
        drive(1'b0, 18'h00010, 8'h00);
        tick();
        check_value("frz_ram_kept", u_bus.ram_load_data, 8'hA5);
        check_value("frz_head_c0",  u_bus.uart_tx_data,  8'hC0);
        u_bus.uart_tx_ready = 1'b1;
        tick();
        check_value("frz_head_c1", u_bus.uart_tx_data, 8'hC1);
        tick();
        check_value("frz_no_d0", u_bus.uart_tx_valid, 1'b0);

        // Sticky finish, cleared only by reset
        u_bus.uart_tx_ready = 1'b0;
        drive(1'b1, 18'h30004, 8'h00);
        tick();
        check_value("finish_set", u_bus.program_finish, 1'b1);
        drive(1'b0, 18'h00010, 8'h00);
        tick();
        tick();
        tick();
        check_value("finish_held", u_bus.program_finish, 1'b1);
        rst_n_in = 1'b0;
        #1;
        check_value("async_rst_finish", u_bus.program_finish, 1'b0);
        check_value("async_rst_load",   u_bus.ram_load_data,  8'h00);
        tick();
        tick();
        rst_n_in = 1'b1;
        tick();
        check_value("ram_survives_rst", u_bus.ram_load_data, 8'hA5);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_io_responder.md
MEM_IO_RESPONDER -- requirements
Module: mem_io_responder

Interface
REQ-001 Parameters SHALL be: ADDR_WIDTH, default 17, RAM byte-address width (2^17 bytes); FIFO_AW, default 3, TX FIFO depth log2 (8 entries).
REQ-002 Clocking SHALL be one clock; reset is asynchronous and active-low.
REQ-003 clk_in  in  1  system clock, all state on posedge.
REQ-004 rst_n_in  in  1  asynchronous active-low reset.
REQ-005 rdy_in  in  1  high = operate; low = freeze all state.
REQ-006 rw_select  in  1  0 read, 1 write.
REQ-007 addr_in  in  18  byte address from initiator.
REQ-008 ram_store_data  in  8  write byte.
REQ-009 ram_load_data  out  8  registered read byte.
REQ-010 io_buffer_full  out  1  TX FIFO near-full back-pressure to initiator.
REQ-011 uart_tx_data  out  8  TX FIFO head byte.
REQ-012 uart_tx_valid  out  1  TX FIFO non-empty.
REQ-013 uart_tx_ready  in  1  sink accepts head byte.
REQ-014 uart_rx_data  in  8  incoming byte.
REQ-015 uart_rx_valid  in  1  incoming byte present.
REQ-016 uart_rx_pop  out  1  one-cycle pulse consuming uart_rx_data.
REQ-017 program_finish  out  1  sticky halt flag.

Function
REQ-018 Decode SHALL be: addr_in[17:16]==2'b11 -> IO space; otherwise RAM at addr_in[ADDR_WIDTH-1:0].
REQ-019 RAM read SHALL register mem[addr] into ram_load_data at the posedge where addr_in is sampled (one-cycle latency, byte valid the cycle after address).
REQ-020 RAM write (rw_select=1) SHALL update mem[addr] with ram_store_data at that posedge; ram_load_data holds its previous value.
REQ-021 IO write 0x30000 SHALL push ram_store_data into TX FIFO; when FIFO holds 2^FIFO_AW entries the byte is dropped, no pointer change.
REQ-022 IO write 0x30004 SHALL set program_finish=1; it stays set until reset.
REQ-023 IO read 0x30000 SHALL return uart_rx_data and pulse uart_rx_pop when uart_rx_valid=1; return 8'h00, no pop, when uart_rx_valid=0.
REQ-024 IO read 0x30004 SHALL return {7'b0, uart_rx_valid}; other IO addresses read 8'h00, writes ignored.
REQ-025 TX drain: byte transfers when uart_tx_valid && uart_tx_ready; read pointer advances by one.
REQ-026 Simultaneous push and drain SHALL leave count unchanged; both pointers advance; wrap-around modulo 2^FIFO_AW.
REQ-027 io_buffer_full SHALL be registered, high when count >= 2^FIFO_AW-2 (headroom for in-flight store).
REQ-028 rdy_in=0 SHALL freeze RAM, FIFO, pointers, outputs; no pop, no push, no drain.
REQ-029 uart_tx_data SHALL equal FIFO head combinationally from storage; undefined when empty.

Reset
REQ-030 rst_n_in low SHALL immediately clear ram_load_data=0, FIFO pointers/count=0, io_buffer_full=0, uart_tx_valid=0, uart_rx_pop=0, program_finish=0.
REQ-031 RAM contents SHALL NOT be reset; reset mid-drain discards FIFO contents.

Configuration
REQ-032 Macro MEM_IO_RX_EN defined: REQ-023 RX path active. Undefined: reads of 0x30000 return 8'h00, uart_rx_pop tied 0, 0x30004 read returns 8'h00, uart_rx_* inputs unused.

Verification
REQ-033 Write 0xA5 to RAM 0x00010, next cycle read 0x00010 -> ram_load_data=0xA5 one cycle after address.
REQ-034 Eight IO writes 0x30000 bytes 0x01..0x08, uart_tx_ready=0 -> io_buffer_full high after 6th push, 7th-8th stored, 9th dropped; ready=1 then drains 0x01..0x08 in order.
REQ-035 Push with uart_tx_ready=1 and non-empty FIFO same cycle -> count unchanged, order preserved across pointer wrap.
REQ-036 uart_rx_valid=1, data 0x5A, read 0x30000 -> ram_load_data=0x5A, uart_rx_pop one cycle; without MEM_IO_RX_EN -> 0x00, no pop.
REQ-037 rdy_in=0 for 3 cycles during write/drain -> no RAM or FIFO change; IO write 0x30004 -> program_finish=1 held until rst_n_in low.
